// File: rtl/dsp_simd_mul_queue_scb.sv
// Queued scoreboard for the SIMD unsigned-data x signed-coefficient multiplier family.
// The reference model pushes expected per-lane products, DUV results pop and are compared
// lane by lane, so any DUV latency of one or more cycles is absorbed by the queue.
// Optional first-error capture is enabled by defining SCB_FIRST_ERR_CAPTURE_EN.
module dsp_simd_mul_queue_scb #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned A_W     = 8,
  parameter int unsigned C_W     = 9,
  parameter int unsigned P_W     = 18,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     scoreboard_en,
  input  logic                     scoreboard_reset,
  input  logic                     ref_valid,
  input  logic [LANES*A_W-1:0]     ref_data,
  input  logic [C_W-1:0]           ref_coeff,
  input  logic [LANES*P_W-1:0]     ref_prod,
  input  logic                     duv_valid,
  input  logic [LANES*P_W-1:0]     duv_prod,
  output logic [31:0]              test_count,
  output logic [31:0]              error_count,
  output logic [LANES*32-1:0]      lane_error_count,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     timeout
`ifdef SCB_FIRST_ERR_CAPTURE_EN
  ,
  output logic                     first_err_valid,
  output logic [LANES-1:0]         first_err_lane_mask,
  output logic [31:0]              first_err_index,
  output logic [A_W-1:0]           first_err_data,
  output logic [C_W-1:0]           first_err_coeff,
  output logic [P_W-1:0]           first_err_exp,
  output logic [P_W-1:0]           first_err_got
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
  localparam logic [IW-1:0] TimeoutCnt = IW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StBusy, StHung} wd_state_e;

  logic [LANES*P_W-1:0] mem_prod [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          test_cnt_q, err_cnt_q;
  logic [31:0]          lane_err_q [LANES];
  logic                 overflow_q, underflow_q, timeout_q;
  wd_state_e            state_q;
  logic [IW-1:0]        idle_q, idle_inc;

  logic                 active, empty, full, push, pop, drop, under, any_mis;
  logic [LANES*P_W-1:0] rd_prod;
  logic [LANES-1:0]     lane_mis;

  // Handshake decode; scoreboard_reset masks both valids for the cycle.
  always_comb begin
    active   = scoreboard_en && !scoreboard_reset;
    empty    = (cnt_q == '0);
    full     = (cnt_q == FullCnt);
    pop      = active && duv_valid && !empty;
    push     = active && ref_valid && (!full || pop);
    drop     = active && ref_valid && full && !pop;
    under    = active && duv_valid && empty;
    rd_prod  = mem_prod[rd_ptr_q];
    idle_inc = idle_q + IW'(1);
    cnt_d    = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  // Per-lane 4-state compare so X/Z from the DUV counts as a mismatch.
  always_comb begin
    lane_mis = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mis[i] = (duv_prod[i*P_W +: P_W] !== rd_prod[i*P_W +: P_W]);
    end
    any_mis = pop && (|lane_mis);
  end

  // Expected-product storage; pointers alone define validity so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem_prod[wr_ptr_q] <= ref_prod;
  end

  // Queue pointers, statistics and sticky overflow/underflow flags.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      test_cnt_q  <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_err_q[i] <= '0;
    end else if (scoreboard_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      test_cnt_q  <= '0;
      err_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < LANES; i++) lane_err_q[i] <= '0;
    end else if (scoreboard_en) begin
      cnt_q <= cnt_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        test_cnt_q <= test_cnt_q + 32'd1;
      end
      if (any_mis || under) err_cnt_q <= err_cnt_q + 32'd1;
      if (drop) overflow_q <= 1'b1;
      if (under) underflow_q <= 1'b1;
      for (int i = 0; i < LANES; i++) begin
        if (pop && lane_mis[i]) lane_err_q[i] <= lane_err_q[i] + 32'd1;
      end
    end
  end

  // Hang watchdog: counts enabled cycles without a pop while entries are outstanding.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= StIdle;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (scoreboard_reset) begin
      state_q   <= StIdle;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else if (scoreboard_en) begin
      unique case (state_q)
        StIdle: begin
          if (push) begin
            state_q <= StBusy;
            idle_q  <= '0;
          end
        end
        StBusy: begin
          if (cnt_d == '0) begin
            state_q <= StIdle;
            idle_q  <= '0;
          end else if (pop) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_inc;
            if (idle_inc == TimeoutCnt) begin
              timeout_q <= 1'b1;
              state_q   <= StHung;
            end
          end
        end
        StHung: begin
          // Timeout stays sticky even after draining back to idle.
          if (cnt_d == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign test_count  = test_cnt_q;
  assign error_count = err_cnt_q;
  assign pending     = cnt_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign timeout     = timeout_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane_out
    assign lane_error_count[g*32 +: 32] = lane_err_q[g];
  end

`ifdef SCB_FIRST_ERR_CAPTURE_EN
  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LANES*A_W-1:0] mem_data [DEPTH];
  logic [C_W-1:0]       mem_coeff [DEPTH];
  logic [LANES*A_W-1:0] rd_data;
  logic [LW-1:0]        low_lane;
  logic [A_W-1:0]       sel_data;
  logic [P_W-1:0]       sel_exp, sel_got;

  logic                 fe_valid_q;
  logic [LANES-1:0]     fe_mask_q;
  logic [31:0]          fe_index_q;
  logic [A_W-1:0]       fe_data_q;
  logic [C_W-1:0]       fe_coeff_q;
  logic [P_W-1:0]       fe_exp_q, fe_got_q;

  // Operand storage kept alongside the products for error reporting.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q]  <= ref_data;
      mem_coeff[wr_ptr_q] <= ref_coeff;
    end
  end

  // Select the lowest mismatching lane for the capture fields.
  always_comb begin
    rd_data  = mem_data[rd_ptr_q];
    low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (lane_mis[i]) low_lane = LW'(i);
    end
    sel_data = rd_data[low_lane*A_W +: A_W];
    sel_exp  = rd_prod[low_lane*P_W +: P_W];
    sel_got  = duv_prod[low_lane*P_W +: P_W];
  end

  // Latch the first mismatching pop and freeze until cleared.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fe_valid_q <= 1'b0;
      fe_mask_q  <= '0;
      fe_index_q <= '0;
      fe_data_q  <= '0;
      fe_coeff_q <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else if (scoreboard_reset) begin
      fe_valid_q <= 1'b0;
      fe_mask_q  <= '0;
      fe_index_q <= '0;
      fe_data_q  <= '0;
      fe_coeff_q <= '0;
      fe_exp_q   <= '0;
      fe_got_q   <= '0;
    end else if (scoreboard_en && any_mis && !fe_valid_q) begin
      fe_valid_q <= 1'b1;
      fe_mask_q  <= lane_mis;
      fe_index_q <= test_cnt_q;
      fe_data_q  <= sel_data;
      fe_coeff_q <= mem_coeff[rd_ptr_q];
      fe_exp_q   <= sel_exp;
      fe_got_q   <= sel_got;
    end
  end

  assign first_err_valid     = fe_valid_q;
  assign first_err_lane_mask = fe_mask_q;
  assign first_err_index     = fe_index_q;
  assign first_err_data      = fe_data_q;
  assign first_err_coeff     = fe_coeff_q;
  assign first_err_exp       = fe_exp_q;
  assign first_err_got       = fe_got_q;
`else
  // Operands are only needed for first-error capture.
  logic unused_ref_operands;
  assign unused_ref_operands = ^{ref_data, ref_coeff};
`endif

endmodule
